// File: rtl/popcount_frame_accumulator.sv
// Accumulates per-word ones counts over a frame of WORDS beats into a saturating total,
// tracks the largest per-word count, and pulses frame_done once the frame is complete.
module popcount_frame_accumulator #(
    parameter int unsigned WORDS = 8,
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       cnt_in,
    input  logic             cnt_valid,
    output logic             cnt_ready,
    output logic [ACC_W-1:0] total,
    output logic [3:0]       max_cnt,
    output logic [7:0]       words_seen,
    output logic             sat,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [ACC_W-1:0] TotalMax = '1;
    localparam logic [7:0]       LastBeat = 8'(WORDS - 1);

    state_e           state_q;
    logic [ACC_W-1:0] total_q;
    logic [3:0]       max_q;
    logic [7:0]       words_q;
    logic             sat_q;
    logic             busy_q;
    logic             done_q;
    logic [ACC_W:0]   sum;

    // One extra bit so the carry-out flags saturation.
    assign sum = {1'b0, total_q} + {{(ACC_W - 3){1'b0}}, cnt_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            total_q <= '0;
            max_q   <= '0;
            words_q <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StAccum;
                        busy_q  <= 1'b1;
                        total_q <= '0;
                        max_q   <= '0;
                        words_q <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                StAccum: begin
                    if (cnt_valid) begin
                        if (sum[ACC_W]) begin
                            total_q <= TotalMax;
                            sat_q   <= 1'b1;
                        end else begin
                            total_q <= sum[ACC_W-1:0];
                        end
                        if (cnt_in > max_q) begin
                            max_q <= cnt_in;
                        end
                        words_q <= words_q + 8'd1;
                        if (words_q == LastBeat) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_ready  = (state_q == StAccum);
    assign total      = total_q;
    assign max_cnt    = max_q;
    assign words_seen = words_q;
    assign sat        = sat_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
